// File: rtl/ysyx_22040365_pkg.sv
// Shared definitions for the ysyx_22040365 NPC core: register-file FSM states
// and default register-file geometry.
package ysyx_22040365_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_e;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 64;
    localparam int RF_NR_RD  = 2;

endpackage

// File: rtl/ysyx_22040365_regfile_mp_if.sv
// Register-file bus: clear handshake, write port and packed multi-port reads.
// master = decode/issue + WB side, slave = register file.
interface ysyx_22040365_regfile_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NR_RD      = 2
);
    logic                        clr_req;
    logic                        ready;
    logic                        wen;
    logic [ADDR_WIDTH-1:0]       waddr;
    logic [DATA_WIDTH-1:0]       wdata;
    logic [NR_RD-1:0]            ren;
    logic [NR_RD*ADDR_WIDTH-1:0] raddr;
    logic [NR_RD*DATA_WIDTH-1:0] rdata;

    modport master (
        output clr_req, wen, waddr, wdata, ren, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clr_req, wen, waddr, wdata, ren, raddr,
        output ready, rdata
    );
endinterface

// File: rtl/ysyx_22040365_rf_rdport.sv
// One register-file read port: optional write bypass, zero-index forcing and
// a hold register that replays the last presented value while ren is low.
// Bypass is compiled in when YSYX_22040365_RF_BYPASS_EN is defined.
module ysyx_22040365_rf_rdport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] entry,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] presented;
    logic [DATA_WIDTH-1:0] hold_q;

    // active is low in CLEAR and while rst is high, so everything reads as 0 then.
    always_comb begin
        presented = entry;
`ifdef YSYX_22040365_RF_BYPASS_EN
        if (wen && (waddr == raddr) && ((ZERO_REG == 0) || (waddr != '0)))
            presented = wdata;
`endif
        if ((ZERO_REG != 0) && (raddr == '0))
            presented = '0;
        if (!active)
            presented = '0;
    end

`ifndef YSYX_22040365_RF_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wen, waddr, wdata};
`endif

    always_ff @(posedge clk) begin
        if (rst)
            hold_q <= '0;
        else if (ren)
            hold_q <= presented;
    end

    assign rdata = !active ? '0 : (ren ? presented : hold_q);

endmodule

// File: rtl/ysyx_22040365_regfile_mp.sv
// Multi-read-port integer register file with hardwired x0, per-port read hold
// and a hardware clear sweep after reset or clr_req. Optional same-cycle write
// bypass via YSYX_22040365_RF_BYPASS_EN.
module ysyx_22040365_regfile_mp
    import ysyx_22040365_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int NR_RD      = RF_NR_RD,
    parameter int ZERO_REG   = 1
) (
    input logic                       clk,
    input logic                       rst,
    ysyx_22040365_regfile_mp_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // clr_req takes priority over a same-cycle write, which is discarded.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_we  = 1'b0;
        mem_wa  = bus.waddr;
        mem_wd  = bus.wdata;
        case (state_q)
            RF_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = '0;
                idx_d  = idx_q + 1'b1;
                if (idx_q == {ADDR_WIDTH{1'b1}})
                    state_d = RF_RUN;
            end
            RF_RUN: begin
                if (bus.clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end else if (bus.wen && !((ZERO_REG != 0) && (bus.waddr == '0))) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                idx_d   = '0;
            end
        endcase
        if (rst)
            mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    assign active    = (state_q == RF_RUN) && !rst;
    assign bus.ready = active;

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        ysyx_22040365_rf_rdport #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ZERO_REG   (ZERO_REG)
        ) u_rdport (
            .clk    (clk),
            .rst    (rst),
            .active (active),
            .ren    (bus.ren[i]),
            .raddr  (ra),
            .entry  (mem[ra]),
            .wen    (bus.wen),
            .waddr  (bus.waddr),
            .wdata  (bus.wdata),
            .rdata  (bus.rdata[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
